// File: rtl/serializador.sv
// serializador: parallel-to-serial transmitter with per-bit write strobe.
// A word is loaded in IDLE and shifted out one bit per accepted beat.
// ready_in can stall the shifting for any number of cycles without losing bits.
// Optional build macro SERIALIZADOR_PARITY_EN adds an even-parity beat
// after the data bits.
module serializador #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_100KHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_in,
  input  logic             ready_in,
  output logic             ack_out,
  output logic             busy_out,
  output logic             data_out,
  output logic             write_out,
  output logic             done_out
);

  // The counter must be able to hold the index of the parity beat (WIDTH).
  localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIALIZADOR_PARITY_EN
  localparam int LAST = WIDTH;       // data bits 0..WIDTH-1, then the parity beat
`else
  localparam int LAST = WIDTH - 1;   // only the data bits
`endif

  localparam logic [CW-1:0] LAST_IDX = CW'(LAST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg_next;
  logic             head;

`ifdef SERIALIZADOR_PARITY_EN
  logic parity;

  // Even parity of a word: the extra bit makes the total number of ones even.
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  // The register moves toward its head so the next bit to send is always there.
  assign shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg[WIDTH-1:1]};

  // Select the bit presented on the link: the head of the register, or parity.
  always_comb begin
    head = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
`ifdef SERIALIZADOR_PARITY_EN
    if (cnt == CW'(WIDTH)) begin
      head = parity;
    end else begin
      head = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end
`endif
  end

  // The link only sees data and a strobe while a word is being shifted.
  always_comb begin
    if (state == SHIFT) begin
      data_out  = head;
      write_out = ready_in;
    end else begin
      data_out  = 1'b0;
      write_out = 1'b0;
    end
  end

  // Control FSM: load in IDLE, shift on ready beats, one-cycle DONE pulse.
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      ack_out  <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      ack_out  <= 1'b0;
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (load_in) begin
            shreg    <= data_in;
            cnt      <= '0;
            state    <= SHIFT;
            ack_out  <= 1'b1;
            busy_out <= 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
            parity   <= even_parity(data_in);
`endif
          end
        end
        SHIFT: begin
          if (ready_in) begin
            shreg <= shreg_next;
            if (cnt == LAST_IDX) begin
              // Last beat transferred; clearing avoids wrapping the counter.
              cnt      <= '0;
              state    <= DONE;
              done_out <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializador.sv
`timescale 1ns/1ps
// Directed bench for serializador: one MSB-first and one LSB-first instance.
module tb_serializador;

`ifdef SERIALIZADOR_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  // MSB-first instance
  logic [7:0] din1;
  logic ld1, rdy1;
  logic a1, b1, o1, w1, dn1;
  // LSB-first instance
  logic [7:0] din0;
  logic ld0, rdy0;
  logic a0, b0, o0, w0, dn0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serializador #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk_100KHz(clk), .reset(rst), .data_in(din1), .load_in(ld1), .ready_in(rdy1),
    .ack_out(a1), .busy_out(b1), .data_out(o1), .write_out(w1), .done_out(dn1)
  );

  serializador #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_100KHz(clk), .reset(rst), .data_in(din0), .load_in(ld0), .ready_in(rdy0),
    .ack_out(a0), .busy_out(b0), .data_out(o0), .write_out(w0), .done_out(dn0)
  );

  // Compare {ack, busy, write, data, done}
  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed={ack,busy,wr,dat,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Load w into the MSB-first instance and follow the whole word.
  // stall[c]=1 drops ready_in in cycle c; pulse_c injects a 0xFF load in that cycle.
  task automatic xmit1(input string tag, input logic [7:0] w,
                       input logic [15:0] stall, input int pulse_c);
    int b;
    int c;
    logic eb;
    logic r;
    ld1 = 1'b1; din1 = w; rdy1 = 1'b1;
    tick();
    ld1 = 1'b0; din1 = ~w;
    b = 0; c = 1;
    while (b < NB && c < 40) begin
      r = (c < 16) ? !stall[c] : 1'b1;
      rdy1 = r;
      if (c == pulse_c) begin ld1 = 1'b1; din1 = 8'hFF; end
      else begin ld1 = 1'b0; end
      #1;
      eb = (b < 8) ? w[7-b] : ^w;
      chk5($sformatf("%s_c%0d", tag, c), {a1, b1, w1, o1, dn1},
           {(c == 1), 1'b1, r, eb, 1'b0});
      if (r) b++;
      c++;
      tick();
    end
    chk_int({tag, "_beats"}, b, NB);
    ld1 = 1'b0; rdy1 = 1'b1; #1;
    chk5({tag, "_done"}, {a1, b1, w1, o1, dn1}, 5'b01001);
    tick(); #1;
    chk5({tag, "_idle"}, {a1, b1, w1, o1, dn1}, 5'b00000);
  endtask

  initial begin
    logic [17:0] exp0;
    logic [7:0] wa;
    logic [7:0] wb;
    int ack_c[2];
    int n_ack;
    int nb;

    rst = 1'b1; ld1 = 1'b0; ld0 = 1'b0; rdy1 = 1'b1; rdy0 = 1'b1;
    din1 = 8'h00; din0 = 8'h00;
    tick(); tick(); #1;
    chk5("reset1", {a1, b1, w1, o1, dn1}, 5'b00000);
    chk5("reset0", {a0, b0, w0, o0, dn0}, 5'b00000);
    rst = 1'b0;
    tick(); #1;
    chk5("idle_after_reset", {a1, b1, w1, o1, dn1}, 5'b00000);

    // 0xA5 with ready high throughout
    xmit1("a5", 8'hA5, 16'h0000, -1);
    // 0x3C with ready low on cycles 3-6
    xmit1("3c_stall", 8'h3C, 16'b0000_0000_0111_1000, -1);
    // 0x00 with a 0xFF load request injected mid-word (must be ignored)
    xmit1("ign_ff", 8'h00, 16'h0000, 3);
    tick(); #1;
    chk5("ign_ff_stay_idle", {a1, b1, w1, o1, dn1}, 5'b00000);

    // Reset after the 4th bit of 0xF0
    ld1 = 1'b1; din1 = 8'hF0; rdy1 = 1'b1;
    tick();
    ld1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk5($sformatf("f0_c%0d", c), {a1, b1, w1, o1, dn1}, {(c == 1), 1'b1, 1'b1, 1'b1, 1'b0});
      tick();
    end
    rst = 1'b1; #1;
    chk5("f0_async_reset", {a1, b1, w1, o1, dn1}, 5'b00000);
    tick(); #1;
    chk5("f0_reset_held", {a1, b1, w1, o1, dn1}, 5'b00000);
    rst = 1'b0;
    tick(); #1;
    chk5("f0_no_done", {a1, b1, w1, o1, dn1}, 5'b00000);
    xmit1("81", 8'h81, 16'h0000, -1);

`ifdef SERIALIZADOR_PARITY_EN
    xmit1("par07", 8'h07, 16'h0000, -1);
`endif

    // LSB-first back-to-back 0x01 then 0x80, load held high
    wa = 8'h01; wb = 8'h80;
    exp0 = '0;
    for (int i = 0; i < 8; i++) begin
      exp0[i]      = wa[i];
      exp0[NB + i] = wb[i];
    end
`ifdef SERIALIZADOR_PARITY_EN
    exp0[8]      = ^wa;
    exp0[NB + 8] = ^wb;
`endif
    n_ack = 0; nb = 0; ack_c[0] = 0; ack_c[1] = 0;
    ld0 = 1'b1; din0 = wa;
    tick();
    for (int c = 1; c < 2 * (NB + 2) + 4; c++) begin
      #1;
      if (a0) begin
        if (n_ack < 2) ack_c[n_ack] = c;
        n_ack++;
        din0 = wb;
        if (n_ack >= 2) ld0 = 1'b0;
      end
      if (w0) begin
        if (nb < 2 * NB) begin
          total++;
          assert (o0 === exp0[nb]) else begin
            bad++;
            $error("FAIL lsb_beat%0d observed=%b expected=%b", nb, o0, exp0[nb]);
          end
        end
        nb++;
      end
      tick();
    end
    ld0 = 1'b0;
    chk_int("lsb_ack_count", n_ack, 2);
    chk_int("lsb_first_ack_cycle", ack_c[0], 1);
    chk_int("lsb_ack_spacing", ack_c[1] - ack_c[0], NB + 2);
    chk_int("lsb_beat_count", nb, 2 * NB);
    #1;
    chk5("lsb_idle_end", {a0, b0, w0, o0, dn0}, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
